set_pattern_driver: RTL and testbench
=====================================

Name: set_pattern_driver

Overview:
- Hardware initiator for the SET candidate-counting interface; replaces the software bench sequencer on the on-chip self-test path.
- Walks NUM_PAT entries of an external synchronous pattern ROM holding central, radius and expected candidate.
- For each entry: waits for SET not busy, issues a one-cycle en with operands, waits for valid, compares candidate against expected, accumulates errors.
- Reports done, pass, error count and the first failing index.

Parameters:
NUM_PAT, 64, patterns per run (1..2^AW)
AW, 6, pattern ROM address width
ERR_LIMIT, 10, error count that aborts the run early
TIMEOUT, 1023, max cycles waiting for busy low or valid, per pattern, before it is counted as an error

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
start  in  1  one-cycle run request, honoured only in IDLE
mode_sel  in  2  SET mode for the run, latched on accepted start
pat_addr  out  AW  ROM address, registered
pat_central  in  24  ROM central word, valid the cycle after pat_addr changes
pat_radius  in  12  ROM radius word, same timing
pat_expected  in  8  ROM expected candidate, same timing
en  out  1  SET request strobe
central  out  24  SET operand
radius  out  12  SET operand
mode  out  2  SET mode
busy  in  1  SET busy
valid  in  1  SET result valid
candidate  in  8  SET result
running  out  1  high from accepted start until done
done  out  1  one-cycle pulse at end of run
pass  out  1  registered; 1 if the last run had zero errors
err_cnt  out  7  errors in current/last run, saturates at 127
fail_idx  out  AW  index of first failing pattern
fail_seen  out  1  fail_idx is meaningful
timeout_seen  out  1  at least one pattern timed out

Behaviour:
- Reset (rst=0, async): state IDLE; all outputs 0, including pat_addr, central, radius, mode, pass, err_cnt and flags. A reset mid-run abandons the run with no done pulse.
- FSM states: IDLE, FETCH, LOAD, WAIT_IDLE, ISSUE, WAIT_VALID, CHECK, DONE.
- IDLE:
  - start=1 latches mode_sel into mode.
  - Clears err_cnt, fail_seen, timeout_seen and pass.
  - Sets pat_addr=0 and running=1, then goes to FETCH.
  - start in any other state is ignored.
- FETCH: one wait cycle for ROM latency, then LOAD.
- LOAD:
  - Registers pat_central into central and pat_radius into radius.
  - Registers pat_expected into an internal register.
  - Clears the timeout counter, then goes to WAIT_IDLE.
- WAIT_IDLE: leaves when busy=0, going to ISSUE. If the counter reaches TIMEOUT, the pattern is counted as an error with timeout_seen=1 and the FSM goes to CHECK-advance without issuing.
- ISSUE:
  - en=1 for exactly this one cycle; en is 0 in every other state.
  - Clears the counter and goes to WAIT_VALID.
- WAIT_VALID:
  - valid is sampled only here, starting the cycle after en.
  - On valid=1, candidate is registered that cycle and the FSM goes to CHECK.
  - Counter reaching TIMEOUT counts as an error with timeout_seen=1.
  - valid seen in any other state is ignored.
- Operand hold: central, radius and mode stay stable from ISSUE until the next LOAD.
- CHECK:
  - Mismatch (candidate != expected, full 8-bit compare) or timeout increments err_cnt, saturating at 127.
  - On the first error, fail_idx=pat_addr and fail_seen=1.
  - Then: if err_cnt (post-increment) == ERR_LIMIT, or pat_addr == NUM_PAT-1, go to DONE.
  - Otherwise pat_addr+1 and go to FETCH. No wrap; the address never exceeds NUM_PAT-1.
- DONE:
  - done=1 for one cycle, running=0.
  - pass=(err_cnt==0), held until the next accepted start.
  - Returns to IDLE.
- Latency per pattern, with SET idle and a valid delay of L cycles after en: FETCH, LOAD, WAIT_IDLE, ISSUE, L cycles, CHECK = L+5 cycles.
- Simultaneous events: busy=0 and a timeout in the same WAIT_IDLE cycle is treated as busy=0, with no error. valid=1 and a timeout in the same cycle is treated as valid.

Test Plan:
- Four patterns, SET model valid 3 cycles after en, all match -> 4 en pulses each exactly 1 cycle wide; done 32 cycles after start; pass=1; err_cnt=0.
- Pattern 2 expected=8'h0C, model returns 8'h0B -> err_cnt=1, fail_idx=2, fail_seen=1, pass=0, run completes all patterns.
- Every candidate wrong, NUM_PAT=64 -> abort after pattern 9: err_cnt=10, fail_idx=0, done pulse, pat_addr=9.
- Model holds busy=1 for 40 cycles before pattern 0 -> en issued the cycle after busy falls; central/radius equal ROM word 0; no error.
- Model never asserts valid, TIMEOUT=15 -> timeout_seen=1, err_cnt increments, sequencer advances to the next pattern.
- rst pulled low during WAIT_VALID of pattern 5 -> outputs 0 immediately; after release a new start runs from pat_addr=0 and stray valid/start before then are ignored.

Source files
------------

// File: rtl/set_pattern_driver.sv
// set_pattern_driver
// On-chip self-test initiator for the SET candidate-counting interface.
// Walks NUM_PAT entries of an external synchronous pattern ROM (central,
// radius, expected candidate), issues one SET request per entry, compares the
// returned candidate with the expected one and accumulates an error count.
// A run ends after the last pattern or as soon as ERR_LIMIT errors are seen.
//
// SET handshake: en is a single-cycle request strobe raised only after busy
// has been observed low; central/radius/mode are held stable from that cycle
// until the next pattern is loaded. The result is taken on the first cycle
// valid is high while waiting for it (starting the cycle after en); valid in
// any other cycle is ignored. If busy stays high, or valid never arrives,
// within TIMEOUT cycles the pattern is scored as an error and the walk moves on.
module set_pattern_driver #(
   parameter int NUM_PAT   = 64,
   parameter int AW        = 6,
   parameter int ERR_LIMIT = 10,
   parameter int TIMEOUT   = 1023
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [1:0]    mode_sel,
   output logic [AW-1:0] pat_addr,
   input  logic [23:0]   pat_central,
   input  logic [11:0]   pat_radius,
   input  logic [7:0]    pat_expected,
   output logic          en,
   output logic [23:0]   central,
   output logic [11:0]   radius,
   output logic [1:0]    mode,
   input  logic          busy,
   input  logic          valid,
   input  logic [7:0]    candidate,
   output logic          running,
   output logic          done,
   output logic          pass,
   output logic [6:0]    err_cnt,
   output logic [AW-1:0] fail_idx,
   output logic          fail_seen,
   output logic          timeout_seen,
   output logic [2:0]    dbg_state
);

   // Timeout counter just wide enough to reach TIMEOUT.
   localparam int            CW        = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] TMO_MAX   = CW'(TIMEOUT);
   localparam logic [AW-1:0] LAST_ADDR = AW'(NUM_PAT - 1);
   localparam logic [31:0]   ERR_LIM   = 32'(ERR_LIMIT);
   localparam logic [6:0]    ERR_SAT   = 7'd127;

   typedef enum logic [2:0] {
      S_IDLE       = 3'd0,
      S_FETCH      = 3'd1,
      S_LOAD       = 3'd2,
      S_WAIT_IDLE  = 3'd3,
      S_ISSUE      = 3'd4,
      S_WAIT_VALID = 3'd5,
      S_CHECK      = 3'd6,
      S_DONE       = 3'd7
   } state_t;

   state_t        state_q, state_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [23:0]   central_q, central_d;
   logic [11:0]   radius_q, radius_d;
   logic [1:0]    mode_q, mode_d;
   logic [7:0]    exp_q, exp_d;
   logic [7:0]    cand_q, cand_d;
   logic          tmo_q, tmo_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [6:0]    err_q, err_d;
   logic [AW-1:0] fidx_q, fidx_d;
   logic          fseen_q, fseen_d;
   logic          tseen_q, tseen_d;
   logic          pass_q, pass_d;
   logic          running_q, running_d;

   // Per-pattern scoring helpers, only meaningful in CHECK.
   logic          pat_err;
   logic [6:0]    err_next;

   // Next-state and datapath updates for the pattern walk.
   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      central_d = central_q;
      radius_d  = radius_q;
      mode_d    = mode_q;
      exp_d     = exp_q;
      cand_d    = cand_q;
      tmo_d     = tmo_q;
      cnt_d     = cnt_q;
      err_d     = err_q;
      fidx_d    = fidx_q;
      fseen_d   = fseen_q;
      tseen_d   = tseen_q;
      pass_d    = pass_q;
      running_d = running_q;
      pat_err   = tmo_q || (cand_q != exp_q);
      err_next  = (pat_err && (err_q != ERR_SAT)) ? err_q + 7'd1 : err_q;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               mode_d    = mode_sel;
               err_d     = '0;
               fseen_d   = 1'b0;
               tseen_d   = 1'b0;
               pass_d    = 1'b0;
               addr_d    = '0;
               running_d = 1'b1;
               state_d   = S_FETCH;
            end
         end

         // The ROM needs one cycle after an address change.
         S_FETCH: begin
            state_d = S_LOAD;
         end

         S_LOAD: begin
            central_d = pat_central;
            radius_d  = pat_radius;
            exp_d     = pat_expected;
            cnt_d     = '0;
            tmo_d     = 1'b0;
            state_d   = S_WAIT_IDLE;
         end

         // busy low wins over a simultaneous timeout.
         S_WAIT_IDLE: begin
            if (!busy) begin
               state_d = S_ISSUE;
            end else if (cnt_q == TMO_MAX) begin
               tmo_d   = 1'b1;
               tseen_d = 1'b1;
               state_d = S_CHECK;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end

         S_ISSUE: begin
            cnt_d   = '0;
            state_d = S_WAIT_VALID;
         end

         // valid wins over a simultaneous timeout.
         S_WAIT_VALID: begin
            if (valid) begin
               cand_d  = candidate;
               state_d = S_CHECK;
            end else if (cnt_q == TMO_MAX) begin
               tmo_d   = 1'b1;
               tseen_d = 1'b1;
               state_d = S_CHECK;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end

         S_CHECK: begin
            err_d = err_next;
            if (pat_err && !fseen_q) begin
               fidx_d  = addr_q;
               fseen_d = 1'b1;
            end
            if (({25'd0, err_next} == ERR_LIM) || (addr_q == LAST_ADDR)) begin
               running_d = 1'b0;
               state_d   = S_DONE;
            end else begin
               addr_d  = addr_q + AW'(1);
               state_d = S_FETCH;
            end
         end

         S_DONE: begin
            pass_d  = (err_q == 7'd0);
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and datapath registers; reset abandons any run in flight.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= S_IDLE;
         addr_q    <= '0;
         central_q <= '0;
         radius_q  <= '0;
         mode_q    <= '0;
         exp_q     <= '0;
         cand_q    <= '0;
         tmo_q     <= 1'b0;
         cnt_q     <= '0;
         err_q     <= '0;
         fidx_q    <= '0;
         fseen_q   <= 1'b0;
         tseen_q   <= 1'b0;
         pass_q    <= 1'b0;
         running_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         central_q <= central_d;
         radius_q  <= radius_d;
         mode_q    <= mode_d;
         exp_q     <= exp_d;
         cand_q    <= cand_d;
         tmo_q     <= tmo_d;
         cnt_q     <= cnt_d;
         err_q     <= err_d;
         fidx_q    <= fidx_d;
         fseen_q   <= fseen_d;
         tseen_q   <= tseen_d;
         pass_q    <= pass_d;
         running_q <= running_d;
      end
   end

   // Strobes are pure state decodes of the registered state.
   assign en           = (state_q == S_ISSUE);
   assign done         = (state_q == S_DONE);
   assign pat_addr     = addr_q;
   assign central      = central_q;
   assign radius       = radius_q;
   assign mode         = mode_q;
   assign running      = running_q;
   assign pass         = pass_q;
   assign err_cnt      = err_q;
   assign fail_idx     = fidx_q;
   assign fail_seen    = fseen_q;
   assign timeout_seen = tseen_q;
   assign dbg_state    = state_q;

endmodule

// File: tb/tb_set_pattern_driver.sv
// tb_set_pattern_driver
// Two sequencer instances share one pattern ROM image and one SET model:
// instance 0 walks 4 patterns (TIMEOUT 63), instance 1 walks 64 (TIMEOUT 15).
// Runs are issued one at a time; the stimulus pushes the expected SET
// requests and run outcome, and the monitor pops them when the DUT shows
// en or done.
module tb_set_pattern_driver;

   localparam int N = 2;

   typedef struct packed {
      logic [23:0] c;
      logic [11:0] r;
      logic [1:0]  m;
      logic        bf;
   } op_t;

   typedef struct packed {
      int          cyc;
      logic [6:0]  err;
      logic        fs;
      logic [5:0]  fi;
      logic        ts;
      logic [5:0]  la;
      logic        ps;
   } run_t;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   // ---------------- DUT signals ----------------
   logic        start[N];
   logic [1:0]  mode_sel[N];
   logic [5:0]  pat_addr[N];
   logic [23:0] pat_central[N];
   logic [11:0] pat_radius[N];
   logic [7:0]  pat_expected[N];
   logic        en[N];
   logic [23:0] central[N];
   logic [11:0] radius[N];
   logic [1:0]  mode[N];
   logic        busy[N];
   logic        valid[N];
   logic [7:0]  candidate[N];
   logic        running[N];
   logic        done[N];
   logic        pass[N];
   logic [6:0]  err_cnt[N];
   logic [5:0]  fail_idx[N];
   logic        fail_seen[N];
   logic        timeout_seen[N];
   logic [2:0]  dbg_state[N];

   for (genvar g = 0; g < N; g++) begin : g_dut
      set_pattern_driver #(
         .NUM_PAT   (g == 0 ? 4 : 64),
         .AW        (6),
         .ERR_LIMIT (10),
         .TIMEOUT   (g == 0 ? 63 : 15)
      ) u_dut (
         .clk          (clk),
         .rst          (rst),
         .start        (start[g]),
         .mode_sel     (mode_sel[g]),
         .pat_addr     (pat_addr[g]),
         .pat_central  (pat_central[g]),
         .pat_radius   (pat_radius[g]),
         .pat_expected (pat_expected[g]),
         .en           (en[g]),
         .central      (central[g]),
         .radius       (radius[g]),
         .mode         (mode[g]),
         .busy         (busy[g]),
         .valid        (valid[g]),
         .candidate    (candidate[g]),
         .running      (running[g]),
         .done         (done[g]),
         .pass         (pass[g]),
         .err_cnt      (err_cnt[g]),
         .fail_idx     (fail_idx[g]),
         .fail_seen    (fail_seen[g]),
         .timeout_seen (timeout_seen[g]),
         .dbg_state    (dbg_state[g])
      );
   end

   // ---------------- pattern ROM (synchronous, 1-cycle) ----------------
   logic [23:0] rom_c[64];
   logic [11:0] rom_r[64];
   logic [7:0]  rom_e[64];

   always @(posedge clk) begin
      for (int u = 0; u < N; u++) begin
         pat_central[u]  <= rom_c[pat_addr[u]];
         pat_radius[u]   <= rom_r[pat_addr[u]];
         pat_expected[u] <= rom_e[pat_addr[u]];
      end
   end

   // ---------------- SET model ----------------
   int         ncyc;
   int         lat[N];
   bit         no_valid[N];
   int         busy_end[N];
   int         inject_at[N];
   int         pend[N];
   logic [7:0] resp[64];

   always @(negedge clk) begin
      ncyc++;
      for (int u = 0; u < N; u++) begin
         busy[u]  = (ncyc < busy_end[u]);
         valid[u] = 1'b0;
         if (pend[u] > 0) begin
            pend[u]--;
            if (pend[u] == 0) begin
               valid[u]     = 1'b1;
               candidate[u] = resp[central[u][5:0]];
            end
         end
         if (ncyc == inject_at[u]) begin
            valid[u]     = 1'b1;
            candidate[u] = 8'h5A;
         end
         if (en[u] && !no_valid[u]) pend[u] = lat[u];
      end
   end

   // ---------------- scoreboard ----------------
   op_t  op_q[$];
   run_t run_q[$];
   int   n_chk;
   int   n_pass;
   int   stim_to;
   int   to_seen;

   task automatic chk(input string name, input int u, input logic [127:0] act,
                      input logic [127:0] req);
      n_chk++;
      if (act === req) n_pass++;
      else $display("FAIL %s (dut%0d): got %0h expected %0h", name, u, act, req);
   endtask

   logic en_prev[N], busy_prev[N], run_prev[N], pass_pend[N], pass_exp[N];
   int   cyc[N];
   bit   rst_checked;

   always begin
      @(posedge clk or negedge rst);
      #1;
      if (!rst) begin
         if (!rst_checked) begin
            for (int u = 0; u < N; u++)
               chk("reset_outputs", u,
                   {pat_addr[u], central[u], radius[u], mode[u], en[u], running[u],
                    done[u], pass[u], err_cnt[u], fail_idx[u], fail_seen[u],
                    timeout_seen[u], dbg_state[u]}, '0);
            rst_checked = 1'b1;
         end
         for (int u = 0; u < N; u++) begin
            en_prev[u]   = 1'b0;
            busy_prev[u] = busy[u];
            run_prev[u]  = 1'b0;
            pass_pend[u] = 1'b0;
         end
      end else begin
         rst_checked = 1'b0;
         if (stim_to != to_seen) begin
            n_chk++;
            $display("FAIL wait_bound: %0d stimulus waits expired, required 0", stim_to - to_seen);
            to_seen = stim_to;
         end
         for (int u = 0; u < N; u++) begin
            if (en[u]) begin
               op_t o;
               chk("en_single_cycle", u, en_prev[u], 0);
               chk("en_expected", u, op_q.size() != 0, 1);
               if (op_q.size() != 0) begin
                  o = op_q.pop_front();
                  chk("operands", u, {central[u], radius[u], mode[u]}, {o.c, o.r, o.m});
                  if (o.bf) chk("en_after_busy_fall", u, {busy_prev[u], busy[u]}, 2'b10);
               end
            end
            if (running[u] && !run_prev[u]) cyc[u] = 0;
            else cyc[u]++;
            if (pass_pend[u]) begin
               chk("pass", u, pass[u], pass_exp[u]);
               pass_pend[u] = 1'b0;
            end
            if (done[u]) begin
               run_t r;
               chk("done_expected", u, run_q.size() != 0, 1);
               if (run_q.size() != 0) begin
                  r = run_q.pop_front();
                  chk("err_cnt", u, err_cnt[u], r.err);
                  chk("fail_seen", u, fail_seen[u], r.fs);
                  if (r.fs) chk("fail_idx", u, fail_idx[u], r.fi);
                  chk("timeout_seen", u, timeout_seen[u], r.ts);
                  chk("final_pat_addr", u, pat_addr[u], r.la);
                  chk("running_low_at_done", u, running[u], 0);
                  if (r.cyc >= 0) chk("cycles_to_done", u, cyc[u], r.cyc);
                  chk("all_en_seen", u, op_q.size(), 0);
                  pass_pend[u] = 1'b1;
                  pass_exp[u]  = r.ps;
               end
            end
            en_prev[u]   = en[u];
            busy_prev[u] = busy[u];
            run_prev[u]  = running[u];
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic push_ops(input int first, input int n, input logic [1:0] m, input bit bf);
      op_t o;
      for (int i = first; i < first + n; i++) begin
         o.c  = rom_c[i];
         o.r  = rom_r[i];
         o.m  = m;
         o.bf = bf && (i == first);
         op_q.push_back(o);
      end
   endtask

   task automatic push_run(input int c, input logic [6:0] e, input logic fs,
                           input logic [5:0] fi, input logic ts, input logic [5:0] la,
                           input logic ps);
      run_t r;
      r.cyc = c; r.err = e; r.fs = fs; r.fi = fi; r.ts = ts; r.la = la; r.ps = ps;
      run_q.push_back(r);
   endtask

   task automatic start_run(input int u, input logic [1:0] m);
      @(negedge clk);
      mode_sel[u] = m;
      start[u]    = 1'b1;
      @(negedge clk);
      start[u]    = 1'b0;
   endtask

   task automatic wait_done(input int u, input int budget);
      bit found;
      found = 1'b0;
      for (int k = 0; k < budget && !found; k++) begin
         @(posedge clk);
         #1;
         found = done[u];
      end
      if (!found) stim_to++;
      repeat (3) @(negedge clk);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      bit found;
      rst = 1'b1;
      for (int u = 0; u < N; u++) begin
         start[u]     = 1'b0;
         mode_sel[u]  = 2'b00;
         lat[u]       = 3;
         no_valid[u]  = 1'b0;
         busy_end[u]  = 0;
         inject_at[u] = -1;
      end
      for (int i = 0; i < 64; i++) begin
         rom_c[i] = 24'hA50000 | 24'(i);
         rom_r[i] = 12'h300 | 12'(i);
         rom_e[i] = 8'(i * 4 + 4);
         resp[i]  = rom_e[i];
      end
      #2 rst = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;

      // Four matching patterns, latency 3; a second start mid-run is ignored.
      push_ops(0, 4, 2'b10, 1'b0);
      push_run(32, 7'd0, 1'b0, 6'd0, 1'b0, 6'd3, 1'b1);
      start_run(0, 2'b10);
      repeat (10) @(negedge clk);
      mode_sel[0] = 2'b11;
      start[0]    = 1'b1;
      @(negedge clk);
      start[0]    = 1'b0;
      wait_done(0, 200);

      // Pattern 2 expects 0C, SET answers 0B.
      resp[2] = 8'h0B;
      push_ops(0, 4, 2'b01, 1'b0);
      push_run(32, 7'd1, 1'b1, 6'd2, 1'b0, 6'd3, 1'b0);
      start_run(0, 2'b01);
      wait_done(0, 200);
      resp[2] = rom_e[2];

      // Every candidate wrong on the 64-pattern instance: abort after pattern 9.
      for (int i = 0; i < 64; i++) resp[i] = ~rom_e[i];
      lat[1] = 1;
      push_ops(0, 10, 2'b11, 1'b0);
      push_run(60, 7'd10, 1'b1, 6'd0, 1'b0, 6'd9, 1'b0);
      start_run(1, 2'b11);
      wait_done(1, 500);
      for (int i = 0; i < 64; i++) resp[i] = rom_e[i];
      lat[1] = 3;

      // SET busy for 40 cycles before pattern 0.
      busy_end[0] = ncyc + 40;
      push_ops(0, 4, 2'b10, 1'b1);
      push_run(-1, 7'd0, 1'b0, 6'd0, 1'b0, 6'd3, 1'b1);
      start_run(0, 2'b10);
      wait_done(0, 300);

      // valid never arrives: every pattern times out, abort at 10 errors.
      no_valid[1] = 1'b1;
      push_ops(0, 10, 2'b01, 1'b0);
      push_run(-1, 7'd10, 1'b1, 6'd0, 1'b1, 6'd9, 1'b0);
      start_run(1, 2'b01);
      wait_done(1, 600);
      no_valid[1] = 1'b0;

      // Reset during WAIT_VALID of pattern 5, then stray start/valid.
      push_ops(0, 6, 2'b10, 1'b0);
      start_run(1, 2'b10);
      found = 1'b0;
      for (int k = 0; k < 2000 && !found; k++) begin
         @(posedge clk);
         #1;
         found = (pat_addr[1] == 6'd5) && (dbg_state[1] == 3'd5);
      end
      if (!found) stim_to++;
      #2 rst = 1'b0;
      mode_sel[1] = 2'b01;
      start[1]    = 1'b1;
      repeat (2) @(negedge clk);
      start[1]    = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      inject_at[1] = ncyc + 2;
      repeat (10) @(negedge clk);

      // Fresh full run after reset starts from pattern 0.
      push_ops(0, 64, 2'b11, 1'b0);
      push_run(512, 7'd0, 1'b0, 6'd0, 1'b0, 6'd63, 1'b1);
      start_run(1, 2'b11);
      wait_done(1, 2000);

      repeat (3) @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
